// File: rtl/alu6_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu6_pkg
// Description : Shared definitions for the 6-bit ALU command controller.
//               Provides the datapath width, the command codes and the
//               controller FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu6_pkg;

    localparam int W = 6;

    // Command codes carried on cmd_op; codes 6 and 7 behave as CMD_READ.
    localparam logic [2:0] OP_SHIFT   = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_NEG     = 3'd2;
    localparam logic [2:0] OP_ABSDIFF = 3'd3;
    localparam logic [2:0] CMD_LOAD   = 3'd4;
    localparam logic [2:0] CMD_READ   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : alu6_pkg
`default_nettype wire

// File: rtl/alu6_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : alu6_ref_model
// Description : Combinational reference of the ALU behaviour that software
//               depends on. Used by alu6_ctrl to flag result mismatches.
// Ports       : a, b  - operands (W bits)
//               op    - ALU op (2 bits)
//               y     - expected result, mod 2^W
// Revision    : 1.0 - initial release
// ============================================================================
module alu6_ref_model #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y
);

    logic [W-1:0] w_dbl;

    // 2a is truncated to W bits before the difference is taken.
    assign w_dbl = a << 1;

    always_comb begin
        y = '0;
        case (op)
            2'd0:    y = (a << 2) + (b >> 1);
            2'd1:    y = a + b + (b << 1);
            2'd2:    y = '0 - b;
            default: y = (w_dbl >= b) ? (w_dbl - b) : (b - w_dbl);
        endcase
    end

endmodule : alu6_ref_model
`default_nettype wire

// File: rtl/alu6_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu6_ctrl
// Description : Command-driven front end for the 6-bit ALU. Holds an NREG x W
//               register file, issues registered operands/op to the ALU,
//               writes the ALU result back and returns one response beat per
//               command. One command in flight at a time.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               cmd_valid/cmd_ready, cmd_op, cmd_ra/rb/rd, cmd_imm
//                                               - command channel
//               alu_a, alu_b, alu_op, alu_out   - ALU interface
//               rsp_valid/rsp_ready, rsp_data, rsp_rd, rsp_err
//                                               - response channel
// Config      : ALU6_CTRL_CHECK_EN - when defined, compares alu_out against an
//               internal reference model and reports rsp_err on mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module alu6_ctrl #(
    parameter int NREG = 4,
    parameter int W    = alu6_pkg::W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [$clog2(NREG)-1:0] cmd_ra,
    input  logic [$clog2(NREG)-1:0] cmd_rb,
    input  logic [$clog2(NREG)-1:0] cmd_rd,
    input  logic [W-1:0]            cmd_imm,
    output logic [W-1:0]            alu_a,
    output logic [W-1:0]            alu_b,
    output logic [1:0]              alu_op,
    input  logic [W-1:0]            alu_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [W-1:0]            rsp_data,
    output logic [$clog2(NREG)-1:0] rsp_rd,
    output logic                    rsp_err
);

    import alu6_pkg::*;

    localparam int c_aw = $clog2(NREG);

    state_t          r_state;
    logic            r_cmd_ready;
    logic            r_rsp_valid;
    logic [W-1:0]    r_rsp_data;
    logic [c_aw-1:0] r_rsp_rd;
    logic [W-1:0]    r_alu_a;
    logic [W-1:0]    r_alu_b;
    logic [1:0]      r_alu_op;
    logic [c_aw-1:0] r_rd;
    logic [W-1:0]    r_regs [NREG];
    logic            w_accept;

    assign w_accept = cmd_valid && r_cmd_ready;

    // cmd_ready is registered: it is low in reset and rises on the first edge
    // after release, and again on the edge that completes a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_rd    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rd        <= '0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        if (!cmd_op[2]) begin
                            // Operands are captured now, so rd may alias ra/rb.
                            r_alu_a  <= r_regs[cmd_ra];
                            r_alu_b  <= r_regs[cmd_rb];
                            r_alu_op <= cmd_op[1:0];
                            r_rd     <= cmd_rd;
                            r_state  <= ST_EXEC;
                        end else if (cmd_op == CMD_LOAD) begin
                            r_regs[cmd_rd] <= cmd_imm;
                            r_rsp_data     <= cmd_imm;
                            r_rsp_rd       <= cmd_rd;
                            r_rsp_valid    <= 1'b1;
                            r_state        <= ST_RESP;
                        end else begin
                            // READ and the reserved codes 6/7.
                            r_rsp_data  <= r_regs[cmd_ra];
                            r_rsp_rd    <= cmd_ra;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    r_regs[r_rd] <= alu_out;
                    r_rsp_data   <= alu_out;
                    r_rsp_rd     <= r_rd;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU6_CTRL_CHECK_EN
    logic [W-1:0] w_model_y;
    logic         r_rsp_err;

    alu6_ref_model #(
        .W (W)
    ) u_ref_model (
        .a  (r_alu_a),
        .b  (r_alu_b),
        .op (r_alu_op),
        .y  (w_model_y)
    );

    // Cleared on every accept so LOAD/READ responses report no error; set in
    // EXEC from the model comparison and held with the rest of the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_rsp_err <= (w_model_y != alu_out);
        end else if ((r_state == ST_IDLE) && w_accept) begin
            r_rsp_err <= 1'b0;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_rd    = r_rsp_rd;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;

endmodule : alu6_ctrl
`default_nettype wire
